// File: rtl/dp_bram_responder.sv
// rtl/dp_bram_responder.sv - dual-port BRAM responder with init sweep and collision flag
// Stores DEPTH words, clears them to INIT_VALUE after reset, then serves ports A and B
// with registered read data. Port A wins a same-address dual write.
module dp_bram_responder #(
   parameter int                DATA_W      = 48,
   parameter int                ADDR_W      = 10,
   parameter int                WRITE_FIRST = 0,
   parameter logic [DATA_W-1:0] INIT_VALUE  = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_a,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic              we_a,
   input  logic [DATA_W-1:0] data_b,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic              we_b,
   output logic [DATA_W-1:0] q_a,
   output logic [DATA_W-1:0] q_b,
   output logic              ready,
   output logic              collision
);

   localparam int              DEPTH    = 2 ** ADDR_W;
   localparam logic [0:0]      ST_INIT  = 1'b0;
   localparam logic [0:0]      ST_RUN   = 1'b1;
   localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

   logic [DATA_W-1:0] mem [DEPTH];

   logic [0:0]        state_q, state_d;
   logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;
   logic              ready_q, ready_d;
   logic              collision_q, collision_d;
   logic [DATA_W-1:0] q_a_q, q_a_d;
   logic [DATA_W-1:0] q_b_q, q_b_d;

   // Write port 0 is shared between the init sweep and port A; port 1 belongs to port B.
   logic              wr0_en;
   logic [ADDR_W-1:0] wr0_addr;
   logic [DATA_W-1:0] wr0_data;
   logic              wr1_en;
   logic              same_addr;

   // Next-state, write steering and read-data selection.
   always_comb begin
      state_d     = state_q;
      init_ptr_d  = init_ptr_q;
      ready_d     = ready_q;
      collision_d = 1'b0;
      q_a_d       = '0;
      q_b_d       = '0;
      wr0_en      = 1'b0;
      wr0_addr    = addr_a;
      wr0_data    = data_a;
      wr1_en      = 1'b0;
      same_addr   = (addr_a == addr_b);

      if (state_q == ST_INIT) begin
         wr0_en   = 1'b1;
         wr0_addr = init_ptr_q;
         wr0_data = INIT_VALUE;
         if (init_ptr_q == PTR_LAST) begin
            // Pointer parks at the last word; it never wraps back to 0.
            state_d = ST_RUN;
            ready_d = 1'b1;
         end else begin
            init_ptr_d = init_ptr_q + 1'b1;
         end
      end else begin
         ready_d     = 1'b1;
         wr0_en      = we_a;
         // B's write is dropped when A writes the same word: A wins.
         wr1_en      = we_b && !(we_a && same_addr);
         collision_d = same_addr && (we_a || we_b);
         q_a_d       = (we_a && (WRITE_FIRST != 0)) ? data_a : mem[addr_a];
         if (we_b && (WRITE_FIRST != 0)) begin
            q_b_d = (we_a && same_addr) ? data_a : data_b;
         end else begin
            q_b_d = mem[addr_b];
         end
      end
   end

   // Control and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_INIT;
         init_ptr_q  <= '0;
         ready_q     <= 1'b0;
         collision_q <= 1'b0;
         q_a_q       <= '0;
         q_b_q       <= '0;
      end else begin
         state_q     <= state_d;
         init_ptr_q  <= init_ptr_d;
         ready_q     <= ready_d;
         collision_q <= collision_d;
         q_a_q       <= q_a_d;
         q_b_q       <= q_b_d;
      end
   end

   // Memory array; left untouched during the reset cycle itself.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (wr0_en) begin
            mem[wr0_addr] <= wr0_data;
         end
         if (wr1_en) begin
            mem[addr_b] <= data_b;
         end
      end
   end

   assign q_a       = q_a_q;
   assign q_b       = q_b_q;
   assign ready     = ready_q;
   assign collision = collision_q;

endmodule
